smaqa_operand_buffer: RTL and testbench

SMAQA_OPERAND_BUFFER -- requirements
Module: smaqa_operand_buffer

---
 rtl/smaqa_operand_buffer_pkg.sv | 13 +
 rtl/smaqa_operand_buffer_if.sv | 35 +++
 rtl/smaqa_buf_mem.sv | 39 +++
 rtl/smaqa_operand_buffer.sv | 121 ++++++++++++
 tb/tb_smaqa_operand_buffer.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/smaqa_operand_buffer_pkg.sv
// Shared constants and types for the SMAQA operand buffer.
package smaqa_operand_buffer_pkg;

  localparam int unsigned SMAQA_BUF_DEPTH = 128;
  localparam int unsigned SMAQA_WORD_W    = 32;

  // One packed 4x8-bit SIMD operand.
  typedef logic [SMAQA_WORD_W-1:0] smaqa_word_t;

  // Number of words in one read window (one SMAQA128 issue).
  localparam int unsigned SMAQA_WIN_WORDS = 4;

endpackage

// File: rtl/smaqa_operand_buffer_if.sv
// Handshake bundle between the SMAQA sequencer (master) and the operand buffer (slave).
// Signal names keep the buffer's point of view for direction suffixes.
interface smaqa_operand_buffer_if #(
  parameter int unsigned DEPTH = smaqa_operand_buffer_pkg::SMAQA_BUF_DEPTH,
  parameter int unsigned WIDTH = smaqa_operand_buffer_pkg::SMAQA_WORD_W
);

  logic                     clear_i;
  logic                     wr_valid_i;
  logic [WIDTH-1:0]         wr_data0_i;
  logic [WIDTH-1:0]         wr_data1_i;
  logic                     wr_ready_o;
  logic                     rd_req_i;
  logic                     rd_ready_o;
  logic                     rd_valid_o;
  logic [WIDTH-1:0]         rd_data0_o;
  logic [WIDTH-1:0]         rd_data1_o;
  logic [WIDTH-1:0]         rd_data2_o;
  logic [WIDTH-1:0]         rd_data3_o;
  logic                     rd_wrap_o;
  logic [$clog2(DEPTH):0]   fill_o;

  modport slave (
    input  clear_i, wr_valid_i, wr_data0_i, wr_data1_i, rd_req_i,
    output wr_ready_o, rd_ready_o, rd_valid_o, rd_data0_o, rd_data1_o, rd_data2_o, rd_data3_o,
           rd_wrap_o, fill_o
  );

  modport master (
    output clear_i, wr_valid_i, wr_data0_i, wr_data1_i, rd_req_i,
    input  wr_ready_o, rd_ready_o, rd_valid_o, rd_data0_o, rd_data1_o, rd_data2_o, rd_data3_o,
           rd_wrap_o, fill_o
  );

endinterface

// File: rtl/smaqa_buf_mem.sv
// Operand storage: one pair-write port (even/odd words), four combinational read ports.
// Contents are deliberately not reset.
module smaqa_buf_mem
  import smaqa_operand_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = SMAQA_BUF_DEPTH,
  parameter int unsigned WIDTH = SMAQA_WORD_W
) (
  input  logic                       clk_i,
  input  logic                       we_i,
  input  logic [$clog2(DEPTH)-2:0]   wpair_i,
  input  logic [WIDTH-1:0]           wdata0_i,
  input  logic [WIDTH-1:0]           wdata1_i,
  input  logic [$clog2(DEPTH)-1:0]   raddr0_i,
  input  logic [$clog2(DEPTH)-1:0]   raddr1_i,
  input  logic [$clog2(DEPTH)-1:0]   raddr2_i,
  input  logic [$clog2(DEPTH)-1:0]   raddr3_i,
  output logic [WIDTH-1:0]           rdata0_o,
  output logic [WIDTH-1:0]           rdata1_o,
  output logic [WIDTH-1:0]           rdata2_o,
  output logic [WIDTH-1:0]           rdata3_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Pair write: even word from port 0, odd word from port 1.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[{wpair_i, 1'b0}] <= wdata0_i;
      mem_q[{wpair_i, 1'b1}] <= wdata1_i;
    end
  end

  assign rdata0_o = mem_q[raddr0_i];
  assign rdata1_o = mem_q[raddr1_i];
  assign rdata2_o = mem_q[raddr2_i];
  assign rdata3_o = mem_q[raddr3_i];

endmodule

// File: rtl/smaqa_operand_buffer.sv
// SMAQA operand buffer: fills in word pairs, serves 4-word windows and replays from 0
// once the stored weights are exhausted.
// Optional: define SMAQA_BUF_ZERO_PAD_EN to zero window words at or beyond the fill level.
module smaqa_operand_buffer
  import smaqa_operand_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = SMAQA_BUF_DEPTH,
  parameter int unsigned WIDTH = SMAQA_WORD_W
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  smaqa_operand_buffer_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned NW = SMAQA_WIN_WORDS;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             rd_valid_q, rd_valid_d;
  logic             rd_wrap_q, rd_wrap_d;
  logic [WIDTH-1:0] rd_data_q [NW];
  logic [WIDTH-1:0] rd_data_d [NW];

  logic             wr_ready, rd_ready, wr_accept, rd_accept, win_wrap;
  logic [AW-1:0]    raddr [NW];
  logic [WIDTH-1:0] rword [NW];
  logic [WIDTH-1:0] win   [NW];

  smaqa_buf_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_mem (
    .clk_i    (clk_i),
    .we_i     (wr_accept),
    .wpair_i  (wr_ptr_q[AW-1:1]),
    .wdata0_i (bus.wr_data0_i),
    .wdata1_i (bus.wr_data1_i),
    .raddr0_i (raddr[0]),
    .raddr1_i (raddr[1]),
    .raddr2_i (raddr[2]),
    .raddr3_i (raddr[3]),
    .rdata0_o (rword[0]),
    .rdata1_o (rword[1]),
    .rdata2_o (rword[2]),
    .rdata3_o (rword[3])
  );

  // Handshakes; clear blocks both sides so it always wins.
  always_comb begin
    wr_ready  = (wr_ptr_q <= PW'(DEPTH - 2)) && !bus.clear_i;
    rd_ready  = (wr_ptr_q != '0) && !bus.clear_i;
    wr_accept = bus.wr_valid_i && wr_ready;
    rd_accept = bus.rd_req_i && rd_ready;
  end

  // Window addressing; reads see pre-write contents and the pre-write fill level.
  always_comb begin
    win_wrap = (rd_ptr_q + PW'(NW)) >= wr_ptr_q;
    for (int k = 0; k < NW; k++) begin
      raddr[k] = AW'(rd_ptr_q + PW'(k));
`ifdef SMAQA_BUF_ZERO_PAD_EN
      win[k] = ((rd_ptr_q + PW'(k)) >= wr_ptr_q) ? '0 : rword[k];
`else
      win[k] = rword[k];
`endif
    end
  end

  // Pointer and read-register next state.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    rd_valid_d = 1'b0;
    rd_wrap_d  = 1'b0;
    rd_data_d  = rd_data_q;
    if (bus.clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (rd_accept) begin
        rd_valid_d = 1'b1;
        rd_wrap_d  = win_wrap;
        rd_ptr_d   = win_wrap ? '0 : rd_ptr_q + PW'(NW);
        rd_data_d  = win;
      end
      if (wr_accept) begin
        wr_ptr_d = wr_ptr_q + PW'(2);
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_wrap_q  <= 1'b0;
      for (int k = 0; k < NW; k++) rd_data_q[k] <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_valid_q <= rd_valid_d;
      rd_wrap_q  <= rd_wrap_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign bus.wr_ready_o = wr_ready;
  assign bus.rd_ready_o = rd_ready;
  assign bus.rd_valid_o = rd_valid_q;
  assign bus.rd_wrap_o  = rd_wrap_q;
  assign bus.rd_data0_o = rd_data_q[0];
  assign bus.rd_data1_o = rd_data_q[1];
  assign bus.rd_data2_o = rd_data_q[2];
  assign bus.rd_data3_o = rd_data_q[3];
  assign bus.fill_o     = wr_ptr_q;

endmodule

// File: tb/tb_smaqa_operand_buffer.sv
// Bench for smaqa_operand_buffer: directed stimulus, a queue/array reference model checked
// every cycle, and literal expectations for the headline scenarios.
module tb_smaqa_operand_buffer;

  localparam int unsigned DEPTH = 128;
  localparam int unsigned WIDTH = 32;
`ifdef SMAQA_BUF_ZERO_PAD_EN
  localparam bit PadEn = 1'b1;
`else
  localparam bit PadEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  smaqa_operand_buffer_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

  smaqa_operand_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [WIDTH-1:0] m_mem [DEPTH];
  bit               m_wr  [DEPTH];
  int               m_wp = 0;
  int               m_rp = 0;
  bit               m_valid = 0;
  bit               m_wrap = 0;
  logic [WIDTH-1:0] m_data  [4];
  bit               m_known [4];

  always @(posedge clk) begin
    if (!rst_n) begin
      m_wp = 0; m_rp = 0; m_valid = 0; m_wrap = 0;
      for (int k = 0; k < 4; k++) begin m_data[k] = '0; m_known[k] = 1; end
    end else if (bus.clear_i) begin
      m_wp = 0; m_rp = 0; m_valid = 0; m_wrap = 0;
    end else begin
      m_valid = bus.rd_req_i && (m_wp != 0);
      m_wrap  = 0;
      if (m_valid) begin
        for (int k = 0; k < 4; k++) begin
          if (PadEn && (m_rp + k >= m_wp)) begin
            m_data[k] = '0; m_known[k] = 1;
          end else begin
            m_data[k] = m_mem[m_rp + k]; m_known[k] = m_wr[m_rp + k];
          end
        end
        m_wrap = (m_rp + 4 >= m_wp);
        m_rp   = m_wrap ? 0 : m_rp + 4;
      end
      if (bus.wr_valid_i && (m_wp <= DEPTH - 2)) begin
        m_mem[m_wp] = bus.wr_data0_i; m_mem[m_wp + 1] = bus.wr_data1_i;
        m_wr[m_wp] = 1; m_wr[m_wp + 1] = 1;
        m_wp += 2;
      end
    end
  end

  function automatic logic [WIDTH-1:0] dut_word(input int k);
    case (k)
      0: return bus.rd_data0_o;
      1: return bus.rd_data1_o;
      2: return bus.rd_data2_o;
      default: return bus.rd_data3_o;
    endcase
  endfunction

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("wr_ready", 64'(bus.wr_ready_o), 64'((m_wp <= DEPTH - 2) && !bus.clear_i));
    check("rd_ready", 64'(bus.rd_ready_o), 64'((m_wp != 0) && !bus.clear_i));
    check("fill", 64'(bus.fill_o), 64'(m_wp));
    check("rd_valid", 64'(bus.rd_valid_o), 64'(m_valid));
    if (m_valid) begin
      check("rd_wrap", 64'(bus.rd_wrap_o), 64'(m_wrap));
      for (int k = 0; k < 4; k++)
        if (m_known[k]) check($sformatf("rd_data%0d", k), 64'(dut_word(k)), 64'(m_data[k]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1);
    bus.wr_valid_i = 1; bus.wr_data0_i = d0; bus.wr_data1_i = d1;
    cyc();
    bus.wr_valid_i = 0;
  endtask

  task automatic rd();
    bus.rd_req_i = 1;
    cyc();
    bus.rd_req_i = 0;
  endtask

  task automatic clr();
    bus.clear_i = 1;
    cyc();
    bus.clear_i = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.clear_i = 0; bus.wr_valid_i = 0; bus.rd_req_i = 0;
    bus.wr_data0_i = '0; bus.wr_data1_i = '0;
    repeat (2) cyc();
    check("rst rd_valid", 64'(bus.rd_valid_o), 64'd0);
    check("rst fill", 64'(bus.fill_o), 64'd0);
    check("rst rd_wrap", 64'(bus.rd_wrap_o), 64'd0);
    check("rst rd_data0", 64'(bus.rd_data0_o), 64'd0);
    check("rst rd_data3", 64'(bus.rd_data3_o), 64'd0);
    check("rst rd_ready", 64'(bus.rd_ready_o), 64'd0);
    rst_n = 1;
    cyc();

    // Basic write/read: one window, wraps straight back to 0.
    wr(32'h01020304, 32'h05060708);
    wr(32'h11111111, 32'h22222222);
    rd();
    check("wr/rd valid", 64'(bus.rd_valid_o), 64'd1);
    check("wr/rd d0", 64'(bus.rd_data0_o), 64'h01020304);
    check("wr/rd d1", 64'(bus.rd_data1_o), 64'h05060708);
    check("wr/rd d2", 64'(bus.rd_data2_o), 64'h11111111);
    check("wr/rd d3", 64'(bus.rd_data3_o), 64'h22222222);
    check("wr/rd wrap", 64'(bus.rd_wrap_o), 64'd1);
    rd();
    check("wr/rd rd_ptr 0", 64'(bus.rd_data0_o), 64'h01020304);
    cyc();
    check("rd_valid one cycle", 64'(bus.rd_valid_o), 64'd0);

    // Replay: 8 words -> windows at 0,4,0 with wrap 0,1,0.
    clr();
    for (int i = 0; i < 4; i++) wr(32'hA0 + 2 * i, 32'hA1 + 2 * i);
    rd();
    check("replay w0 d0", 64'(bus.rd_data0_o), 64'hA0);
    check("replay w0 wrap", 64'(bus.rd_wrap_o), 64'd0);
    rd();
    check("replay w1 d0", 64'(bus.rd_data0_o), 64'hA4);
    check("replay w1 wrap", 64'(bus.rd_wrap_o), 64'd1);
    rd();
    check("replay w2 d0", 64'(bus.rd_data0_o), 64'hA0);
    check("replay w2 wrap", 64'(bus.rd_wrap_o), 64'd0);

    // Padding: 6 fresh words over the old 8; window at 4 reaches words 6,7.
    clr();
    for (int i = 0; i < 3; i++) wr(32'hB0 + 2 * i, 32'hB1 + 2 * i);
    rd();
    rd();
    check("pad d0", 64'(bus.rd_data0_o), 64'hB4);
    check("pad d1", 64'(bus.rd_data1_o), 64'hB5);
    check("pad d2", 64'(bus.rd_data2_o), PadEn ? 64'd0 : 64'hA6);
    check("pad d3", 64'(bus.rd_data3_o), PadEn ? 64'd0 : 64'hA7);
    check("pad wrap", 64'(bus.rd_wrap_o), 64'd1);

    // Full: 64 pairs fill the buffer, the 65th is dropped.
    clr();
    for (int i = 0; i < 64; i++) wr(32'hC000_0000 + 2 * i, 32'hC000_0001 + 2 * i);
    check("full fill", 64'(bus.fill_o), 64'd128);
    check("full wr_ready", 64'(bus.wr_ready_o), 64'd0);
    wr(32'hDEAD_BEEF, 32'hFEED_F00D);
    check("full 65th fill", 64'(bus.fill_o), 64'd128);
    rd();
    check("full mem0 kept", 64'(bus.rd_data0_o), 64'hC000_0000);

    // Simultaneous write and read: read uses pre-write fill.
    clr();
    wr(32'hD0, 32'hD1);
    wr(32'hD2, 32'hD3);
    bus.rd_req_i = 1; bus.wr_valid_i = 1; bus.wr_data0_i = 32'hE0; bus.wr_data1_i = 32'hE1;
    cyc();
    bus.rd_req_i = 0; bus.wr_valid_i = 0;
    check("rw d3", 64'(bus.rd_data3_o), 64'hD3);
    check("rw wrap", 64'(bus.rd_wrap_o), 64'd1);
    check("rw fill", 64'(bus.fill_o), 64'd6);

    // Priority: clear beats read and write.
    clr();
    for (int i = 0; i < 4; i++) wr(32'hF0 + i, 32'hF8 + i);
    check("prio fill 8", 64'(bus.fill_o), 64'd8);
    bus.clear_i = 1; bus.rd_req_i = 1; bus.wr_valid_i = 1;
    #1;
    check("prio rd_ready comb", 64'(bus.rd_ready_o), 64'd0);
    check("prio wr_ready comb", 64'(bus.wr_ready_o), 64'd0);
    cyc();
    bus.clear_i = 0; bus.rd_req_i = 0; bus.wr_valid_i = 0;
    check("prio fill", 64'(bus.fill_o), 64'd0);
    check("prio rd_valid", 64'(bus.rd_valid_o), 64'd0);
    check("prio rd_ready", 64'(bus.rd_ready_o), 64'd0);

    // Read while empty is ignored.
    rd();
    check("empty rd_valid", 64'(bus.rd_valid_o), 64'd0);

    // Reset right after a read accept aborts it.
    wr(32'h12345678, 32'h9ABCDEF0);
    bus.rd_req_i = 1;
    cyc();
    bus.rd_req_i = 0;
    check("pre-rst rd_valid", 64'(bus.rd_valid_o), 64'd1);
    rst_n = 0;
    cyc();
    check("rst abort rd_valid", 64'(bus.rd_valid_o), 64'd0);
    check("rst abort fill", 64'(bus.fill_o), 64'd0);
    rst_n = 1;
    repeat (2) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
